// File: rtl/dec_scan_pkg.sv
// Shared types and helpers for the dec_scan registered decoder / scanner.
package dec_scan_pkg;

    // Widest index the shared one-hot helper can decode; instances with a
    // wider SEL_W would be truncated, so keep SEL_W at or below this.
    localparam int MAX_SEL_W = 8;
    localparam int MAX_N     = 1 << MAX_SEL_W;

    // Width of the blanking counter; BLANK is limited to 0..15.
    localparam int BLANK_W = 4;

    // Controller states.
    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        DIRECT     = 2'd1,
        SCAN_ON    = 2'd2,
        SCAN_BLANK = 2'd3
    } state_t;

    // One-hot decode of an index into the widest supported vector.
    // Callers cast the result down to their own 2^SEL_W width.
    function automatic logic [MAX_N-1:0] onehot(input logic [MAX_SEL_W-1:0] idx);
        logic [MAX_N-1:0] r;
        r      = '0;
        r[idx] = 1'b1;
        return r;
    endfunction

endpackage

// File: rtl/dec_onehot.sv
// Combinational 1-of-2^SEL_W decoder with enable; all-zero when disabled.
module dec_onehot
    import dec_scan_pkg::*;
#(
    parameter int SEL_W = 4
) (
    input  logic                    en,
    input  logic [SEL_W-1:0]        idx,
    output logic [(1<<SEL_W)-1:0]   sel
);

    localparam int N = 1 << SEL_W;

    // Decode the index when enabled, otherwise drive no select at all.
    always_comb begin
        sel = '0;
        if (en) begin
            sel = N'(onehot(MAX_SEL_W'(idx)));
        end
    end

endmodule

// File: rtl/dec_scan.sv
// Registered one-hot decoder with direct and auto-scan modes.
// Direct mode registers the decode of 'a'. Scan mode walks a single
// select bit through 0..last, holding each for dwell+1 cycles followed
// by BLANK all-zero cycles so that two selects never touch.
module dec_scan
    import dec_scan_pkg::*;
#(
    parameter int SEL_W   = 4,
    parameter int DWELL_W = 8,
    parameter int BLANK   = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic                    mode,
    input  logic [SEL_W-1:0]        a,
    input  logic [DWELL_W-1:0]      dwell,
    input  logic [SEL_W-1:0]        last,
    output logic [(1<<SEL_W)-1:0]   s,
    output logic [SEL_W-1:0]        idx,
    output logic                    wrap
);

    localparam int N = 1 << SEL_W;

    // Blanking is a build-time choice; the counter is loaded with BLANK-1
    // so that it reaches zero after exactly BLANK blank cycles.
    localparam bit                 HAS_BLANK  = (BLANK > 0);
    localparam logic [BLANK_W-1:0] BLANK_LOAD = BLANK_W'((BLANK > 0) ? (BLANK - 1) : 0);

    state_t               state_q, state_d;
    logic [SEL_W-1:0]     idx_q, idx_d;
    logic [N-1:0]         s_q, s_d;
    logic                 wrap_q, wrap_d;
    logic [DWELL_W-1:0]   dwell_cnt_q, dwell_cnt_d;
    logic [BLANK_W-1:0]   blank_cnt_q, blank_cnt_d;

    logic                 dec_en;
    logic [SEL_W-1:0]     dec_idx;
    logic [N-1:0]         dec_sel;

    logic                 adv_wrap;
    logic [SEL_W-1:0]     adv_idx;
    logic                 dwell_done;
    logic                 blank_done;

    // The decoder output is the only source for the select register, so
    // the registered select is one-hot or zero by construction.
    dec_onehot #(
        .SEL_W (SEL_W)
    ) u_dec (
        .en  (dec_en),
        .idx (dec_idx),
        .sel (dec_sel)
    );

    // Index that a scan advance would move to; last is sampled here so a
    // lowered last below the current index wraps on the next advance.
    always_comb begin
        adv_wrap   = (idx_q >= last);
        adv_idx    = adv_wrap ? '0 : (idx_q + SEL_W'(1));
        dwell_done = (dwell_cnt_q == '0);
        blank_done = (blank_cnt_q == '0);
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: enable low wins everywhere, then mode selects
    // between the direct and scan halves of the machine.
    always_comb begin
        state_d = state_q;
        if (!en) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = mode ? SCAN_ON : DIRECT;
                end
                DIRECT: begin
                    state_d = mode ? SCAN_ON : DIRECT;
                end
                SCAN_ON: begin
                    if (!mode) begin
                        state_d = DIRECT;
                    end else if (dwell_done) begin
                        state_d = HAS_BLANK ? SCAN_BLANK : SCAN_ON;
                    end
                end
                SCAN_BLANK: begin
                    if (!mode) begin
                        state_d = DIRECT;
                    end else if (blank_done) begin
                        state_d = SCAN_ON;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // Output and datapath logic: chooses what the decoder drives next,
    // the next index, counter reloads and the wrap pulse.
    always_comb begin
        idx_d       = idx_q;
        wrap_d      = 1'b0;
        dwell_cnt_d = dwell_cnt_q;
        blank_cnt_d = blank_cnt_q;
        dec_en      = 1'b0;
        dec_idx     = idx_q;
        if (en) begin
            case (state_q)
                IDLE, DIRECT: begin
                    if (mode) begin
                        // Entering scan always restarts at index 0, no wrap.
                        idx_d       = '0;
                        dec_idx     = '0;
                        dec_en      = 1'b1;
                        dwell_cnt_d = dwell;
                    end else begin
                        idx_d   = a;
                        dec_idx = a;
                        dec_en  = 1'b1;
                    end
                end
                SCAN_ON: begin
                    if (!mode) begin
                        idx_d   = a;
                        dec_idx = a;
                        dec_en  = 1'b1;
                    end else if (!dwell_done) begin
                        dwell_cnt_d = dwell_cnt_q - DWELL_W'(1);
                        dec_idx     = idx_q;
                        dec_en      = 1'b1;
                    end else if (HAS_BLANK) begin
                        // Break before make: drop the select, index holds.
                        blank_cnt_d = BLANK_LOAD;
                        dec_en      = 1'b0;
                    end else begin
                        idx_d       = adv_idx;
                        dec_idx     = adv_idx;
                        dec_en      = 1'b1;
                        wrap_d      = adv_wrap;
                        dwell_cnt_d = dwell;
                    end
                end
                SCAN_BLANK: begin
                    if (!mode) begin
                        idx_d   = a;
                        dec_idx = a;
                        dec_en  = 1'b1;
                    end else if (!blank_done) begin
                        blank_cnt_d = blank_cnt_q - BLANK_W'(1);
                    end else begin
                        idx_d       = adv_idx;
                        dec_idx     = adv_idx;
                        dec_en      = 1'b1;
                        wrap_d      = adv_wrap;
                        dwell_cnt_d = dwell;
                    end
                end
                default: begin
                    dec_en = 1'b0;
                end
            endcase
        end
    end

    // Select is always the decoder output, giving a glitch-free register.
    always_comb begin
        s_d = dec_sel;
    end

    // Datapath registers: select, index, wrap pulse and the two counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_q         <= '0;
            idx_q       <= '0;
            wrap_q      <= 1'b0;
            dwell_cnt_q <= '0;
            blank_cnt_q <= '0;
        end else begin
            s_q         <= s_d;
            idx_q       <= idx_d;
            wrap_q      <= wrap_d;
            dwell_cnt_q <= dwell_cnt_d;
            blank_cnt_q <= blank_cnt_d;
        end
    end

    assign s    = s_q;
    assign idx  = idx_q;
    assign wrap = wrap_q;

endmodule

// File: doc/dec_scan.md
# dec_scan

Parametrised registered 1-of-2^SEL_W decoder with an auto-scan mode, used to drive row/digit selects of multiplexed displays and channel strobes. In direct mode it registers the one-hot decode of an input index. In scan mode it walks a one-hot select through indices 0..last with a programmable dwell time and break-before-make blanking. It replaces fixed-width combinational decoders wherever the select must be glitch-free and registered.

## Interface
- SEL_W, 4: index width; output width N = 2^SEL_W
- DWELL_W, 8: dwell counter width
- BLANK, 1: all-zero cycles inserted between scan steps, 0..15; 0 disables blanking
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- en  in  1  block enable; low forces outputs inactive
- mode  in  1  0 = direct decode, 1 = auto-scan
- a  in  SEL_W  direct-mode index
- dwell  in  DWELL_W  scan on-time minus one, in cycles
- last  in  SEL_W  highest scan index, inclusive
- s  out  N  registered one-hot select, or all zero
- idx  out  SEL_W  index currently driven on s
- wrap  out  1  one-cycle pulse when scan returns from last to 0

## Operation
- One clock domain. Reset is asynchronous and active-low.
- Reset values: s=0, idx=0, wrap=0, state IDLE, dwell counter 0, blank counter 0.
- States:
  - IDLE: s=0. On en=1, go to DIRECT if mode=0, else go to SCAN_ON with idx=0.
  - DIRECT: s<=1<<a and idx<=a every cycle.
  - SCAN_ON: s=1<<idx. Dwell counter loads dwell on entry and decrements each cycle. At 0, go to SCAN_BLANK if BLANK>0, else advance.
  - SCAN_BLANK: s=0 for exactly BLANK cycles, then advance.
- Advance rule: if idx>=last then idx<=0 and wrap=1 for one cycle; else idx<=idx+1. Then enter SCAN_ON.
- last is sampled at each advance. Lowering last below idx mid-scan wraps at the next advance.
- dwell is sampled on each SCAN_ON entry. A change applies from the next step.
- en=0 in any state: next cycle is IDLE, s=0, wrap=0, idx holds its value. Re-enabling scan always restarts at idx 0.
- mode 1->0 in a scan state: next cycle is DIRECT with s=1<<a. mode 0->1 in DIRECT: next cycle is SCAN_ON, idx=0, no wrap pulse.
- s is never multi-hot. When BLANK>0, two distinct bits are never high on consecutive cycles in scan mode.
- last=0: scan dwells on index 0. wrap pulses once per step.

## Timing
- Direct latency: 1 cycle from a/en to s.
- Scan step period: dwell+1+BLANK cycles. Frame period: (last+1)*(dwell+1+BLANK) cycles.
- dwell=0 gives a 1-cycle on-time.
- wrap is asserted in the same cycle that s first shows index 0 of the new frame.
- en falling: s=0 on the first edge after en is sampled low.
- Reset mid-operation clears all outputs immediately (asynchronous). After rst_n deasserts, the first active edge samples en.

## Structure
- Package dec_scan_pkg:
  - state_t enum {IDLE, DIRECT, SCAN_ON, SCAN_BLANK}
  - function onehot(idx) returning a 2^SEL_W vector
- Sub-module dec_onehot (parametrised SEL_W, combinational, with enable) performs the decode. Its output feeds the s register.
- The top module holds the FSM, dwell counter, blank counter, index register and wrap register.

## Test plan
All scenarios use SEL_W=4, DWELL_W=8, BLANK=1.
- Reset/idle: assert rst_n=0 mid-cycle -> s=0, idx=0, wrap=0 immediately. With en=0 after reset, s stays 0 for 20 cycles.
- Direct sweep: en=1, mode=0, a=0..15, one per cycle -> s=16'h0001<<a one cycle later. Drop en -> s=0 next cycle.
- Scan: mode=1, dwell=2, last=3 -> s sequence 0001 x3, 0000, 0002 x3, 0000, 0004 x3, 0000, 0008 x3, 0000, 0001... Step period 4, frame 16. wrap high with the 0001 after 0008.
- Boundary: last=0, dwell=0 -> s toggles 0001,0000 with wrap each step. During scan at idx=5, change last 9->3 -> next s is 0001 with wrap.
- Mode/enable interplay: switch mode 1->0 at idx=2 with a=7 -> s=0080 next cycle. Scan en low then high -> scan restarts at 0001, no multi-hot on any cycle (assertion).
- BLANK=0 build: dwell=1, last=15 -> no zero cycles, period 2, frame 32, one-hot invariant held throughout.
